// File: rtl/mem_wb_pkg.sv
// rtl/mem_wb_pkg.sv - shared types for the MEM/WB skid stage
package mem_wb_pkg;

    localparam int DATA_W_DEF       = 32;
    localparam int REG_ADDR_W_DEF   = 5;
    localparam int RESULT_SRC_W_DEF = 2;

    typedef struct packed {
        logic [DATA_W_DEF-1:0]       pc_plus4;
        logic [DATA_W_DEF-1:0]       alu_result;
        logic [DATA_W_DEF-1:0]       read_data;
        logic                        reg_write;
        logic [RESULT_SRC_W_DEF-1:0] result_src;
        logic [REG_ADDR_W_DEF-1:0]   rd;
    } mem_wb_payload_t;

    localparam int MEM_WB_PAYLOAD_W = $bits(mem_wb_payload_t);

    typedef enum logic [1:0] {
        EMPTY,
        BUSY,
        FULL
    } skid_state_e;

    function automatic skid_state_e skid_state(input logic main_v, input logic skid_v);
        if (skid_v) begin
            return FULL;
        end else if (main_v) begin
            return BUSY;
        end
        return EMPTY;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - generic 2-entry skid buffer with synchronous flush
module pipe_skid_buf
    import mem_wb_pkg::*;
#(
    parameter int             W              = 8,
    parameter logic [W-1:0]   FLUSH_CLR_MASK = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] data_o
);

    logic         main_valid_q, main_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         accept;
    logic         release_w;
    skid_state_e  state;

    assign state     = skid_state(main_valid_q, skid_valid_q);
    assign ready_o   = !skid_valid_q;
    assign valid_o   = main_valid_q;
    assign data_o    = main_q;
    assign accept    = valid_i && !skid_valid_q;
    assign release_w = main_valid_q && ready_i;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;
        if (flush) begin
            // Payload survives a flush except the bits the owner asks to clear.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            main_d       = main_q & ~FLUSH_CLR_MASK;
            skid_d       = skid_q & ~FLUSH_CLR_MASK;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_d       = data_i;
                        main_valid_d = 1'b1;
                    end
                end
                BUSY: begin
                    if (accept && release_w) begin
                        main_d = data_i;
                    end else if (accept) begin
                        skid_d       = data_i;
                        skid_valid_d = 1'b1;
                    end else if (release_w) begin
                        main_valid_d = 1'b0;
                    end
                end
                default: begin
                    if (release_w) begin
                        main_d       = skid_q;
                        skid_valid_d = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (state != FULL || main_valid_q);
        end
    end

endmodule

// File: rtl/mem_wb_skid_stage.sv
// rtl/mem_wb_skid_stage.sv - MEM/WB handshake stage; MEM_WB_STATS_EN enables stall/flush counters
module mem_wb_skid_stage
    import mem_wb_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int REG_ADDR_WIDTH   = 5,
    parameter int RESULT_SRC_WIDTH = 2,
    parameter int STAT_WIDTH       = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        valid_m,
    output logic                        ready_m,
    input  logic [DATA_WIDTH-1:0]       PCPlus4_m,
    input  logic [DATA_WIDTH-1:0]       ALUResult_m,
    input  logic [DATA_WIDTH-1:0]       ReadData_m,
    input  logic                        RegWrite_m,
    input  logic [RESULT_SRC_WIDTH-1:0] ResultSrc_m,
    input  logic [REG_ADDR_WIDTH-1:0]   Rd_m,
    output logic                        valid_w,
    input  logic                        ready_w,
    output logic [DATA_WIDTH-1:0]       PCPlus4_w,
    output logic [DATA_WIDTH-1:0]       ALUResult_w,
    output logic [DATA_WIDTH-1:0]       ReadData_w,
    output logic                        RegWrite_w,
    output logic [RESULT_SRC_WIDTH-1:0] ResultSrc_w,
    output logic [REG_ADDR_WIDTH-1:0]   Rd_w,
    output logic [STAT_WIDTH-1:0]       stall_cycles,
    output logic [STAT_WIDTH-1:0]       flush_count
);

    localparam int              PW      = 3 * DATA_WIDTH + 1 + RESULT_SRC_WIDTH + REG_ADDR_WIDTH;
    localparam int              RW_BIT  = RESULT_SRC_WIDTH + REG_ADDR_WIDTH;
    localparam logic [PW-1:0]   RW_MASK = PW'(1) << RW_BIT;

    logic          reg_write_in;
    logic [PW-1:0] in_data;
    logic [PW-1:0] out_data;

    // A write to x0 is dropped at capture so writeback never sees it.
    assign reg_write_in = RegWrite_m && (Rd_m != '0);
    assign in_data      = {PCPlus4_m, ALUResult_m, ReadData_m, reg_write_in, ResultSrc_m, Rd_m};

    pipe_skid_buf #(
        .W              (PW),
        .FLUSH_CLR_MASK (RW_MASK)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .valid_i (valid_m),
        .ready_o (ready_m),
        .data_i  (in_data),
        .valid_o (valid_w),
        .ready_i (ready_w),
        .data_o  (out_data)
    );

    assign {PCPlus4_w, ALUResult_w, ReadData_w, RegWrite_w, ResultSrc_w, Rd_w} = out_data;

`ifdef MEM_WB_STATS_EN
    logic [STAT_WIDTH-1:0] stall_cycles_q;
    logic [STAT_WIDTH-1:0] flush_count_q;

    // Any entry valid implies the main entry is valid, so valid_w covers both.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (valid_w && !ready_w && stall_cycles_q != '1) begin
                stall_cycles_q <= stall_cycles_q + STAT_WIDTH'(1);
            end
            if (flush && valid_w && flush_count_q != '1) begin
                flush_count_q <= flush_count_q + STAT_WIDTH'(1);
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(RegWrite_w && Rd_w == '0));
        end
    end

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// tb/tb_mem_wb_skid_stage.sv - scoreboard bench for mem_wb_skid_stage
module tb_mem_wb_skid_stage;
    import mem_wb_pkg::*;

`ifdef MEM_WB_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst, flush, valid_m, ready_w;
    mem_wb_payload_t in_p;
    logic            ready_m, valid_w;
    logic [31:0]     PCPlus4_w, ALUResult_w, ReadData_w;
    logic            RegWrite_w;
    logic [1:0]      ResultSrc_w;
    logic [4:0]      Rd_w;
    logic [31:0]     stall_cycles, flush_count;

    int              n_checks = 0;
    int              n_fail   = 0;
    mem_wb_payload_t sb[$];
    int              stall_m = 0;
    int              flush_m = 0;

    always #5 clk = ~clk;

    mem_wb_skid_stage dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .valid_m      (valid_m),
        .ready_m      (ready_m),
        .PCPlus4_m    (in_p.pc_plus4),
        .ALUResult_m  (in_p.alu_result),
        .ReadData_m   (in_p.read_data),
        .RegWrite_m   (in_p.reg_write),
        .ResultSrc_m  (in_p.result_src),
        .Rd_m         (in_p.rd),
        .valid_w      (valid_w),
        .ready_w      (ready_w),
        .PCPlus4_w    (PCPlus4_w),
        .ALUResult_w  (ALUResult_w),
        .ReadData_w   (ReadData_w),
        .RegWrite_w   (RegWrite_w),
        .ResultSrc_w  (ResultSrc_w),
        .Rd_w         (Rd_w),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    function automatic mem_wb_payload_t obs();
        return {PCPlus4_w, ALUResult_w, ReadData_w, RegWrite_w, ResultSrc_w, Rd_w};
    endfunction

    function automatic mem_wb_payload_t mk(input logic [31:0] alu, input logic rw, input logic [4:0] rd);
        mem_wb_payload_t p;
        p.pc_plus4   = $urandom;
        p.alu_result = alu;
        p.read_data  = $urandom;
        p.reg_write  = rw;
        p.result_src = 2'($urandom_range(0, 3));
        p.rd         = rd;
        return p;
    endfunction

    // Reference model: advances one clock, pushing expected bundles on accept
    // and popping them on release, with flush/reset emptying the queue.
    task automatic tick();
        bit              acc, rel;
        mem_wb_payload_t e;
        acc         = valid_m && (sb.size() < 2);
        rel         = (sb.size() > 0) && ready_w;
        e           = in_p;
        e.reg_write = in_p.reg_write && (in_p.rd != 5'd0);
        if (sb.size() > 0 && !ready_w) stall_m++;
        if (flush && sb.size() > 0) flush_m++;
        @(posedge clk);
        if (rst) begin
            sb.delete();
            stall_m = 0;
            flush_m = 0;
        end else begin
            if (rel) void'(sb.pop_front());
            if (flush) sb.delete();
            else if (acc) sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 1'b0; flush = 1'b0; valid_m = 1'b0; ready_w = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst  = 1'b1;
        in_p = mk(32'h1234, 1'b1, 5'd7);
        tick();
        rst = 1'b0;
        n_checks++; if (valid_w !== 1'b0) begin n_fail++; $display("FAIL reset_valid_w: got %b expected 0", valid_w); end
        n_checks++; if (ready_m !== 1'b1) begin n_fail++; $display("FAIL reset_ready_m: got %b expected 1", ready_m); end
        n_checks++; if (obs() !== '0) begin n_fail++; $display("FAIL reset_payload: got %h expected 0", obs()); end
        n_checks++; if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
            n_fail++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", stall_cycles, flush_count);
        end
    endtask

    task automatic test_streaming();
        idle();
        ready_w = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            valid_m = (i <= 8);
            in_p    = mk(32'(i), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
            n_checks++; if (ready_m !== 1'b1) begin n_fail++; $display("FAIL stream_ready_m[%0d]: got %b expected 1", i, ready_m); end
            n_checks++; if (valid_w !== (i > 1)) begin n_fail++; $display("FAIL stream_valid_w[%0d]: got %b expected %b", i, valid_w, i > 1); end
            if (i > 1) begin
                n_checks++; if (ALUResult_w !== 32'(i - 1)) begin n_fail++; $display("FAIL stream_alu[%0d]: got %h expected %h", i, ALUResult_w, i - 1); end
                n_checks++; if (obs() !== sb[0]) begin n_fail++; $display("FAIL stream_payload[%0d]: got %h expected %h", i, obs(), sb[0]); end
            end
            tick();
        end
        n_checks++; if (valid_w !== 1'b0) begin n_fail++; $display("FAIL stream_drain: got %b expected 0", valid_w); end
    endtask

    task automatic test_backpressure();
        idle();
        valid_m = 1'b1; in_p = mk(32'h10, 1'b1, 5'd1);
        tick();
        n_checks++; if (valid_w !== 1'b1 || ready_m !== 1'b1 || ALUResult_w !== 32'h10) begin
            n_fail++; $display("FAIL bp_busy: got v=%b r=%b alu=%h expected 1 1 10", valid_w, ready_m, ALUResult_w);
        end
        in_p = mk(32'h20, 1'b1, 5'd2);
        tick();
        valid_m = 1'b0;
        n_checks++; if (ready_m !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b expected 0", ready_m); end
        n_checks++; if (ALUResult_w !== 32'h10) begin n_fail++; $display("FAIL bp_hold_a: got %h expected 10", ALUResult_w); end
        tick();
        n_checks++; if (obs() !== sb[0] || ALUResult_w !== 32'h10) begin n_fail++; $display("FAIL bp_stable: got %h expected %h", obs(), sb[0]); end
        ready_w = 1'b1;
        tick();
        n_checks++; if (valid_w !== 1'b1 || ALUResult_w !== 32'h20 || ready_m !== 1'b1) begin
            n_fail++; $display("FAIL bp_b: got v=%b alu=%h r=%b expected 1 20 1", valid_w, ALUResult_w, ready_m);
        end
        n_checks++; if (obs() !== sb[0]) begin n_fail++; $display("FAIL bp_b_payload: got %h expected %h", obs(), sb[0]); end
        tick();
        n_checks++; if (valid_w !== 1'b0 || sb.size() != 0) begin n_fail++; $display("FAIL bp_empty: got %b expected 0", valid_w); end
    endtask

    task automatic test_x0();
        idle();
        ready_w = 1'b1; valid_m = 1'b1;
        in_p = mk(32'h0, 1'b1, 5'd0); in_p.read_data = 32'hDEADBEEF;
        tick();
        in_p = mk(32'h0, 1'b1, 5'd5);
        n_checks++; if (valid_w !== 1'b1 || RegWrite_w !== 1'b0 || ReadData_w !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL x0_suppress: got v=%b rw=%b rd=%h expected 1 0 deadbeef", valid_w, RegWrite_w, ReadData_w);
        end
        tick();
        valid_m = 1'b0;
        n_checks++; if (RegWrite_w !== 1'b1 || Rd_w !== 5'd5 || obs() !== sb[0]) begin
            n_fail++; $display("FAIL x0_rd5: got rw=%b rd=%0d expected 1 5", RegWrite_w, Rd_w);
        end
        tick();
    endtask

    task automatic test_flush();
        idle();
        valid_m = 1'b1; in_p = mk(32'hC1, 1'b1, 5'd3);
        tick();
        in_p = mk(32'hC2, 1'b1, 5'd4);
        tick();
        in_p = mk(32'hC3, 1'b1, 5'd6);
        flush = 1'b1;
        n_checks++; if (ready_m !== 1'b0) begin n_fail++; $display("FAIL flush_full_ready: got %b expected 0", ready_m); end
        tick();
        flush = 1'b0; valid_m = 1'b0;
        n_checks++; if (valid_w !== 1'b0 || RegWrite_w !== 1'b0 || ready_m !== 1'b1) begin
            n_fail++; $display("FAIL flush_full: got v=%b rw=%b r=%b expected 0 0 1", valid_w, RegWrite_w, ready_m);
        end
        ready_w = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (valid_w !== 1'b0) begin n_fail++; $display("FAIL flush_ghost[%0d]: got %b expected 0", i, valid_w); end
            tick();
        end
        ready_w = 1'b0; valid_m = 1'b1; in_p = mk(32'hD1, 1'b1, 5'd9);
        tick();
        in_p = mk(32'hD2, 1'b1, 5'd10); flush = 1'b1; ready_w = 1'b1;
        n_checks++; if (ready_m !== 1'b1 || valid_w !== 1'b1 || ALUResult_w !== 32'hD1) begin
            n_fail++; $display("FAIL flush_busy_pre: got r=%b v=%b alu=%h expected 1 1 d1", ready_m, valid_w, ALUResult_w);
        end
        tick();
        flush = 1'b0; valid_m = 1'b0;
        n_checks++; if (valid_w !== 1'b0 || sb.size() != 0) begin n_fail++; $display("FAIL flush_busy_post: got %b expected 0", valid_w); end
        tick();
    endtask

    task automatic test_reset_mid();
        idle();
        valid_m = 1'b1; in_p = mk(32'h33, 1'b1, 5'd1);
        tick();
        in_p = mk(32'h44, 1'b1, 5'd2);
        tick();
        rst = 1'b1; flush = 1'b1; in_p = mk(32'h99, 1'b1, 5'd3);
        tick();
        rst = 1'b0; flush = 1'b0;
        n_checks++; if (valid_w !== 1'b0 || ready_m !== 1'b1 || obs() !== '0) begin
            n_fail++; $display("FAIL rstmid_state: got v=%b r=%b p=%h expected 0 1 0", valid_w, ready_m, obs());
        end
        ready_w = 1'b1; in_p = mk(32'h55, 1'b1, 5'd8);
        tick();
        valid_m = 1'b0;
        n_checks++; if (valid_w !== 1'b1 || ALUResult_w !== 32'h55 || obs() !== sb[0]) begin
            n_fail++; $display("FAIL rstmid_new: got v=%b alu=%h expected 1 55", valid_w, ALUResult_w);
        end
        tick();
        n_checks++; if (valid_w !== 1'b0) begin n_fail++; $display("FAIL rstmid_alone: got %b expected 0", valid_w); end
    endtask

    task automatic test_stats();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0; valid_m = 1'b1; in_p = mk(32'h77, 1'b1, 5'd4);
        tick();
        valid_m = 1'b0;
        repeat (3) tick();
        flush = 1'b1; ready_w = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++; if (stall_cycles !== (STATS_ON ? 32'd3 : 32'd0) || stall_m != 3) begin
            n_fail++; $display("FAIL stats_stall: got %0d expected %0d", stall_cycles, STATS_ON ? 3 : 0);
        end
        n_checks++; if (flush_count !== (STATS_ON ? 32'd1 : 32'd0) || flush_m != 1) begin
            n_fail++; $display("FAIL stats_flush: got %0d expected %0d", flush_count, STATS_ON ? 1 : 0);
        end
    endtask

    initial begin
        idle();
        in_p = '0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_x0();
        test_flush();
        test_reset_mid();
        test_stats();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wb_skid_stage.md
Name: mem_wb_skid_stage

Overview:
- Parametrised successor to the MEM/WB pipeline register.
- Carries the memory-stage result bundle into writeback over a valid/ready handshake instead of a global enable.
- A 2-entry skid buffer gives full throughput with registered backpressure. Adds synchronous flush and x0 write suppression.
- Sits between the cache-backed memory stage and the register-file write port.

Parameters:
- DATA_WIDTH, 32, width of PCPlus4, ALUResult and ReadData.
- REG_ADDR_WIDTH, 5, destination register index width.
- RESULT_SRC_WIDTH, 2, writeback result-select width.
- STAT_WIDTH, 32, width of the optional statistics counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  synchronous kill of all buffered entries.
- valid_m  in  1  memory stage presents a bundle.
- ready_m  out  1  stage can accept; driven only from registered state.
- PCPlus4_m, ALUResult_m, ReadData_m  in  DATA_WIDTH each  payload.
- RegWrite_m  in  1  payload.
- ResultSrc_m  in  RESULT_SRC_WIDTH  payload.
- Rd_m  in  REG_ADDR_WIDTH  payload.
- valid_w  out  1  writeback bundle valid.
- ready_w  in  1  writeback consumes the bundle.
- PCPlus4_w, ALUResult_w, ReadData_w, RegWrite_w, ResultSrc_w, Rd_w  out  matching widths  registered payload.
- stall_cycles  out  STAT_WIDTH  optional statistic.
- flush_count  out  STAT_WIDTH  optional statistic.

Behaviour:
- Handshakes:
  - Accept = valid_m & ready_m.
  - Release = valid_w & ready_w.
  - ready_m = !skid_valid.
  - No combinational path from ready_w to ready_m, or from any input to any output.
- Storage: main register drives the *_w outputs; skid register holds one overflow bundle.
- State machine (encoded in main_valid/skid_valid):
  - EMPTY, entry condition: valid_w=0, ready_m=1.
    - Accept: main<=in, go to BUSY.
  - BUSY, entry condition: valid_w=1, ready_m=1.
    - Accept and release: main<=in, stay BUSY.
    - Accept only: skid<=in, go to FULL.
    - Release only: go to EMPTY.
    - Neither: hold.
  - FULL, entry condition: valid_w=1, ready_m=0; no accept possible.
    - Release: main<=skid, skid cleared, go to BUSY.
    - Otherwise: hold.
- Latency: 1 cycle from accept to valid_w when EMPTY, or when BUSY with a simultaneous release.
- Order: strictly FIFO. Payload held stable while valid_w & !ready_w.
- x0 suppression: RegWrite is captured as RegWrite_m & (Rd_m != 0). RegWrite_w is never 1 with Rd_w == 0.
- Flush:
  - Clears main_valid, skid_valid and RegWrite_w next edge; next state EMPTY.
  - Data payload bits are left unchanged.
  - Flush beats an accept in the same cycle: the incoming bundle is dropped, but ready_m still reads 1 that cycle if the stage was not FULL.
  - Flush beats release: the consumer sees release this cycle; the entry is then gone.
- Reset (rst=1 at edge):
  - valid_w=0, all payload outputs 0, skid cleared, ready_m=1 from the first cycle after reset.
  - Statistics counters 0.
  - Reset mid-transfer discards everything and overrides flush.
- Non-valid bundles (valid_m=0) are never captured; payload registers do not toggle.

Optional Feature:
- Macro MEM_WB_STATS_EN.
- When defined:
  - stall_cycles increments each cycle with valid_w & !ready_w.
  - flush_count increments each cycle flush=1 while any entry is valid.
  - Both saturate at all-ones; both are cleared only by rst.
- When undefined: both ports tied to 0 and no counter flops are synthesised.

Decomposition:
- Package mem_wb_pkg:
  - typedef mem_wb_payload_t, a packed struct {pc_plus4, alu_result, read_data, reg_write, result_src, rd} sized from the parameters' defaults.
  - Localparam MEM_WB_PAYLOAD_W.
  - enum skid_state_e {EMPTY, BUSY, FULL}, used for assertions/debug.
- Sub-module pipe_skid_buf: a generic 2-entry skid buffer parametrised by payload width, with flush. mem_wb_skid_stage wraps it with packing, x0 suppression and stats.

Test Plan:
- Streaming: valid_m=1 and ready_w=1 for 8 cycles with ALUResult_m=1..8 -> valid_w from cycle 1, ALUResult_w=1..8 back-to-back, ready_m constantly 1.
- Backpressure: BUSY holding A=0x10, ready_w=0, push B=0x20 -> next cycle ready_m=0. Raise ready_w -> outputs A, then B on consecutive cycles, then EMPTY.
- x0: RegWrite_m=1, Rd_m=0, ReadData_m=0xDEADBEEF -> valid_w=1, RegWrite_w=0, ReadData_w=0xDEADBEEF. With Rd_m=5 -> RegWrite_w=1.
- Flush in FULL with a simultaneous valid_m -> next cycle valid_w=0, RegWrite_w=0, ready_m=1. No entry ever emerges for the three bundles involved.
- Reset mid-backpressure (FULL, rst=1 for one cycle) -> all outputs 0, ready_m=1 next cycle. A new bundle 0x55 then emerges alone.
- MEM_WB_STATS_EN: 3 stall cycles plus 1 flush with a valid entry -> stall_cycles=3, flush_count=1. With the macro undefined -> both read 0.
